wvb_reader: RTL and testbench
=============================

# wvb_reader

Drains completed waveforms from the mDOM waveform buffer (WVB). Sits directly downstream of the WVB write controller. For each 160-bit header the write controller pushes into the header FIFO, the block emits the header as five 32-bit words, then streams every sample between the header's start and stop addresses out of the WVB RAM over a valid/ready interface. It returns the freed address range to the write controller so buffer occupancy can be tracked.

## Interface
Parameters:
- P_ADR_WIDTH, 12, WVB RAM address width; the buffer wraps modulo 2^P_ADR_WIDTH
- P_DATA_WIDTH, 22, WVB sample width (discr[7:0], adc[11:0], tot, spare)
- P_HDR_WIDTH, 160, header FIFO word width

Ports (name, direction, width, meaning):
- clk, in, 1, clock
- rst, in, 1, synchronous, active-low reset
- enable, in, 1, permits starting a new event; an event in progress always completes
- hdr_empty, in, 1, header FIFO empty (show-ahead FIFO)
- hdr_data, in, 160, FIFO head; valid whenever hdr_empty=0
- hdr_rdreq, out, 1, one-cycle pop strobe
- wvb_rd_addr, out, 12, RAM read address; RAM returns wvb_data one cycle later
- wvb_data, in, 22, RAM read data
- dout, out, 32, output word
- dout_valid, out, 1, dout holds a valid word
- dout_ready, in, 1, consumer accepts the word when valid and ready are both high
- dout_last, out, 1, marks the final word of the event
- rd_done, out, 1, one-cycle pulse after the last sample word is accepted
- rd_stop_addr, out, 12, stop address of the event just freed; valid with rd_done
- busy, out, 1, high outside IDLE
- evt_count, out, 16, count of completed events; wraps at 2^16

## Operation
- Header fields: ltc = hdr_data[159:112], start_addr = [111:100], stop_addr = [99:88], trig_src = [87:86], cnst_run = [85], overflow = [84]. Bits [83:0] are reserved and are passed through unchanged.
- Sample count: N = (stop_addr - start_addr) mod 4096, plus 1. This gives a range of 1 to 4096.
  - stop_addr < start_addr means the event wrapped around the buffer.
  - Addresses increment modulo 4096.
- Header words are emitted MSB-first: word k = hdr_data[159-32k -: 32], for k = 0..4.
- Sample word = {10'h000, wvb_data}.
- dout_last is asserted only on the last sample word. It is never asserted on a header word.
- State machine:
  - IDLE: if enable=1 and hdr_empty=0, pulse hdr_rdreq, latch hdr_data, go to HDR.
  - HDR: present the 5 header words in order, advancing on each accept. Prefetch starts here: wvb_rd_addr = start_addr.
  - SAMP: stream N samples. After the last sample is accepted, go to DONE.
  - DONE: one cycle. Assert rd_done, drive rd_stop_addr, increment evt_count. Return to IDLE.
- RAM latency is covered by a 2-entry output skid buffer.
  - Throughput is 1 word/cycle while dout_ready=1.
  - A RAM read is issued only when a skid entry is free, so no word is ever lost or duplicated.
- Backpressure: dout, dout_valid and dout_last stay stable while dout_valid=1 and dout_ready=0.
- Deasserting enable mid-event has no effect until the block returns to IDLE.

## Timing
- Reset (rst=0 at a clk edge): all outputs go to 0 on that edge.
  - Covers hdr_rdreq, dout_valid, dout_last, rd_done, busy, evt_count, wvb_rd_addr, rd_stop_addr and dout.
  - State returns to IDLE and the skid buffer is flushed.
  - Reset mid-event abandons the event. The popped header is not restored and no rd_done is issued.
- Start latency: hdr_empty falls at cycle T with enable=1.
  - hdr_rdreq is high at T+1.
  - The first dout_valid (header word 0) is high at T+2.
- The first sample word is valid the cycle after header word 4 is accepted, assuming dout_ready held high.
- Back-to-back events: from the last-sample accept to the next event's header word 0 is 4 cycles (DONE, IDLE pop, latch, present).
- Minimum event length: 5 + N words plus 4 overhead cycles.
- hdr_rdreq is never asserted while hdr_empty=1. It is at most one pulse per event.

## Test plan
- Single event, start=0x010, stop=0x013, dout_ready=1.
  - Required: 5 header words, then 4 samples from RAM[0x010..0x013].
  - dout_last on the 4th sample only.
  - rd_done with rd_stop_addr=0x013; evt_count=1.
- Wrap event, start=0xFFE, stop=0x001.
  - Required: 4 samples, read from addresses FFE, FFF, 000, 001.
- Backpressure: dout_ready toggles 1,0,0,1 repeatedly over the single-event case.
  - Required: identical word sequence, dout stable during stalls, no drops or duplicates.
- Two headers queued, dout_ready=1.
  - Required: second header word 0 valid exactly 4 cycles after the first event's last accept; evt_count=2.
- enable=0 with a header queued.
  - Required: no hdr_rdreq.
  - Setting enable=1 starts the event.
  - Clearing enable mid-SAMP still completes the event.
- rst=0 asserted during SAMP.
  - Required: all outputs 0 next cycle, busy=0, no rd_done.
  - The next queued header is processed normally after rst=1.

Source files
------------

// File: rtl/wvb_reader.sv
// Drains completed waveforms from the WVB: emits each 160-bit header as five
// 32-bit words, then streams the event's samples from RAM through a 2-entry skid.
module wvb_reader #(
    parameter int P_ADR_WIDTH  = 12,
    parameter int P_DATA_WIDTH = 22,
    parameter int P_HDR_WIDTH  = 160
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   enable,
    input  logic                   hdr_empty,
    input  logic [P_HDR_WIDTH-1:0] hdr_data,
    output logic                   hdr_rdreq,
    output logic [P_ADR_WIDTH-1:0] wvb_rd_addr,
    input  logic [P_DATA_WIDTH-1:0] wvb_data,
    output logic [31:0]            dout,
    output logic                   dout_valid,
    input  logic                   dout_ready,
    output logic                   dout_last,
    output logic                   rd_done,
    output logic [P_ADR_WIDTH-1:0] rd_stop_addr,
    output logic                   busy,
    output logic [15:0]            evt_count
);

    localparam int LTC_W    = 48;
    localparam int START_HI = P_HDR_WIDTH - LTC_W - 1;
    localparam int STOP_HI  = START_HI - P_ADR_WIDTH;

    typedef enum logic [1:0] {IDLE, HDR, SAMP, DONE} state_t;

    state_t                 state;
    logic [P_HDR_WIDTH-1:0] hdr_sh;
    logic [2:0]             hdr_idx;
    logic [P_ADR_WIDTH-1:0] stop_addr;
    logic [P_ADR_WIDTH:0]   rd_left;
    logic                   inflight;
    logic                   inflight_last;
    logic [1:0]             cnt;
    logic [31:0]            d1;
    logic                   l1;

    logic                   pop;
    logic                   hdr_push;
    logic                   push;
    logic [31:0]            push_data;
    logic                   push_last;
    logic [1:0]             nxt_cnt;
    logic [1:0]             wpos;
    logic                   issue;

    // dout/dout_last are the skid head; d1/l1 is the second entry.
    always_comb begin
        pop       = dout_valid & dout_ready;
        hdr_push  = (state == HDR) && ((cnt != 2'd2) || pop);
        push      = hdr_push | inflight;
        push_data = hdr_push ? hdr_sh[P_HDR_WIDTH-1 -: 32]
                             : {{(32-P_DATA_WIDTH){1'b0}}, wvb_data};
        push_last = ~hdr_push & inflight_last;
        nxt_cnt   = cnt + {1'b0, push} - {1'b0, pop};
        wpos      = cnt - {1'b0, pop};
        // A read may only be issued if its data, arriving next cycle, is sure to find a free slot.
        issue     = (nxt_cnt != 2'd2) &&
                    (((state == SAMP) && (rd_left != '0)) || (hdr_push && (hdr_idx == 3'd4)));
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state         <= IDLE;
            hdr_sh        <= '0;
            hdr_idx       <= '0;
            stop_addr     <= '0;
            rd_left       <= '0;
            inflight      <= 1'b0;
            inflight_last <= 1'b0;
            cnt           <= '0;
            d1            <= '0;
            l1            <= 1'b0;
            hdr_rdreq     <= 1'b0;
            wvb_rd_addr   <= '0;
            dout          <= '0;
            dout_valid    <= 1'b0;
            dout_last     <= 1'b0;
            rd_done       <= 1'b0;
            rd_stop_addr  <= '0;
            busy          <= 1'b0;
            evt_count     <= '0;
        end else begin
            hdr_rdreq     <= 1'b0;
            rd_done       <= 1'b0;
            cnt           <= nxt_cnt;
            dout_valid    <= (nxt_cnt != 2'd0);
            inflight      <= issue;
            inflight_last <= issue && (rd_left == {{P_ADR_WIDTH{1'b0}}, 1'b1});

            if (pop) begin
                dout      <= d1;
                dout_last <= l1;
                l1        <= 1'b0;
            end
            if (push) begin
                if (wpos == 2'd0) begin
                    dout      <= push_data;
                    dout_last <= push_last;
                end else begin
                    d1 <= push_data;
                    l1 <= push_last;
                end
            end

            if (issue) begin
                wvb_rd_addr <= wvb_rd_addr + 1'b1;
                rd_left     <= rd_left - 1'b1;
            end

            case (state)
                IDLE: begin
                    if (enable && !hdr_empty) begin
                        hdr_rdreq   <= 1'b1;
                        hdr_sh      <= hdr_data;
                        hdr_idx     <= '0;
                        wvb_rd_addr <= hdr_data[START_HI -: P_ADR_WIDTH];
                        stop_addr   <= hdr_data[STOP_HI -: P_ADR_WIDTH];
                        rd_left     <= {1'b0, hdr_data[STOP_HI -: P_ADR_WIDTH]
                                              - hdr_data[START_HI -: P_ADR_WIDTH]}
                                       + {{P_ADR_WIDTH{1'b0}}, 1'b1};
                        busy        <= 1'b1;
                        state       <= HDR;
                    end
                end
                HDR: begin
                    if (hdr_push) begin
                        hdr_sh  <= hdr_sh << 32;
                        hdr_idx <= hdr_idx + 3'd1;
                        if (hdr_idx == 3'd4) state <= SAMP;
                    end
                end
                SAMP: begin
                    // Only the final sample ever carries the last flag.
                    if (pop && dout_last) begin
                        rd_done      <= 1'b1;
                        rd_stop_addr <= stop_addr;
                        evt_count    <= evt_count + 16'd1;
                        state        <= DONE;
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_wvb_reader.sv
// Bench for wvb_reader: header FIFO and RAM models, word scoreboard, event table
// plus hand-written back-to-back, enable and mid-event reset sequences.
module tb_wvb_reader;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         enable = 1'b0;
    logic         hdr_empty;
    logic [159:0] hdr_data;
    logic         hdr_rdreq;
    logic [11:0]  wvb_rd_addr;
    logic [21:0]  wvb_data = '0;
    logic [31:0]  dout;
    logic         dout_valid;
    logic         dout_ready = 1'b0;
    logic         dout_last;
    logic         rd_done;
    logic [11:0]  rd_stop_addr;
    logic         busy;
    logic [15:0]  evt_count;

    wvb_reader dut (
        .clk(clk), .rst(rst), .enable(enable), .hdr_empty(hdr_empty),
        .hdr_data(hdr_data), .hdr_rdreq(hdr_rdreq), .wvb_rd_addr(wvb_rd_addr),
        .wvb_data(wvb_data), .dout(dout), .dout_valid(dout_valid),
        .dout_ready(dout_ready), .dout_last(dout_last), .rd_done(rd_done),
        .rd_stop_addr(rd_stop_addr), .busy(busy), .evt_count(evt_count)
    );

    always #5 clk = ~clk;

    function automatic logic [21:0] ramf(input logic [11:0] a);
        return {a[5:0], 4'hA, a} ^ 22'h2C3A51;
    endfunction

    // show-ahead header FIFO: initial writes tail, the pop process moves head
    logic [159:0] hbuf [16];
    int hd = 0;
    int tl = 0;
    assign hdr_empty = (hd == tl);
    assign hdr_data  = hbuf[hd % 16];
    always @(posedge clk) if (hdr_rdreq && hd != tl) hd <= hd + 1;
    always @(posedge clk) wvb_data <= ramf(wvb_rd_addr);

    typedef struct { int id; logic [31:0] d; logic l; } exp_t;
    typedef struct { int id; logic [11:0] stop; } stop_t;
    typedef struct { logic [11:0] s; logic [11:0] e; int n; bit bp; } vec_t;

    exp_t  expq [$];
    stop_t stopq [$];
    vec_t  tv [6];

    int nchk = 0, nerr = 0, cyc = 0;
    int done_n = 0, rdreq_n = 0, rdreq_cyc = 0, done_cyc = 0;
    int evt_wi = 0, w0_cyc = 0, h4_cyc = 0, s0_cyc = 0, last_cyc = 0, gap = 0;
    bit bp = 0;
    logic [3:0] pat = 4'b1001;
    logic prev_stall = 0, prev_last = 0;
    logic [31:0] prev_dout = '0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic monitor;
        exp_t e;
        stop_t s;
        if (!rst) begin
            prev_stall = 0;
            evt_wi = 0;
            return;
        end
        if (hdr_rdreq) begin
            rdreq_cyc = cyc;
            rdreq_n++;
            chk("rdreq_while_empty", hdr_empty, 0);
        end
        if (prev_stall)
            chk("stall_hold", {dout_valid, dout_last, dout}, {1'b1, prev_last, prev_dout});
        if (dout_valid && dout_ready) begin
            if (expq.size() == 0) begin
                chk("extra_word", {dout_last, dout}, 33'h1FFFFFFFF ^ {dout_last, dout});
            end else begin
                e = expq.pop_front();
                chk("word", {dout_last, dout}, {e.l, e.d});
            end
            if (evt_wi == 0) begin w0_cyc = cyc; gap = cyc - last_cyc; end
            if (evt_wi == 4) h4_cyc = cyc;
            if (evt_wi == 5) s0_cyc = cyc;
            evt_wi++;
            if (dout_last) begin last_cyc = cyc; evt_wi = 0; end
        end
        if (rd_done) begin
            done_n++;
            done_cyc = cyc;
            if (stopq.size() == 0) begin
                chk("spurious_rd_done", rd_done, 0);
            end else begin
                s = stopq.pop_front();
                chk("rd_stop_addr", rd_stop_addr, s.stop);
            end
        end
        prev_stall = dout_valid && !dout_ready;
        prev_dout  = dout;
        prev_last  = dout_last;
    endtask

    task automatic tick;
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
        cyc++;
        if (bp) dout_ready = pat[cyc % 4];
    endtask

    task automatic queue_hdr(input logic [11:0] s, input logic [11:0] e, input int n, input int id);
        logic [159:0] h;
        logic [95:0]  r;
        logic [11:0]  a;
        exp_t x;
        stop_t st;
        r = {$urandom(), $urandom(), $urandom()};
        h = {48'hA5_0000_0000 + 48'(id), s, e, 2'b10, 1'b1, 1'b0, r[83:0]};
        hbuf[tl % 16] = h;
        tl++;
        x.id = id;
        for (int k = 0; k < 5; k++) begin
            x.d = h[159-32*k -: 32];
            x.l = 1'b0;
            expq.push_back(x);
        end
        for (int i = 0; i < n; i++) begin
            a = s + 12'(i);
            x.d = {10'h000, ramf(a)};
            x.l = (i == n - 1);
            expq.push_back(x);
        end
        st.id = id;
        st.stop = e;
        stopq.push_back(st);
    endtask

    task automatic wait_done(input int target, input int budget);
        int k = 0;
        while (done_n < target && k < budget) begin tick(); k++; end
        chk("rd_done_timeout", done_n >= target, 1);
    endtask

    task automatic wait_wi(input int target, input int budget);
        int k = 0;
        while (evt_wi < target && k < budget) begin tick(); k++; end
        chk("word_wait_timeout", evt_wi >= target, 1);
    endtask

    task automatic check_zero(input string p);
        chk({p, "_hdr_rdreq"}, hdr_rdreq, 0);
        chk({p, "_dout_valid"}, dout_valid, 0);
        chk({p, "_dout_last"}, dout_last, 0);
        chk({p, "_rd_done"}, rd_done, 0);
        chk({p, "_busy"}, busy, 0);
        chk({p, "_evt_count"}, evt_count, 0);
        chk({p, "_wvb_rd_addr"}, wvb_rd_addr, 0);
        chk({p, "_rd_stop_addr"}, rd_stop_addr, 0);
        chk({p, "_dout"}, dout, 0);
    endtask

    initial begin
        int id = 0;
        int t0, n0, a_id;
        for (int i = 0; i < 16; i++) hbuf[i] = '0;
        tv[0] = '{12'h010, 12'h013, 4,    1'b0};
        tv[1] = '{12'hFFE, 12'h001, 4,    1'b0};
        tv[2] = '{12'h010, 12'h013, 4,    1'b1};
        tv[3] = '{12'h100, 12'h100, 1,    1'b0};
        tv[4] = '{12'h7F0, 12'h80F, 32,   1'b1};
        tv[5] = '{12'h005, 12'h004, 4096, 1'b0};

        repeat (3) tick();
        check_zero("reset");
        rst = 1'b1;
        enable = 1'b1;
        dout_ready = 1'b1;
        repeat (2) tick();

        for (int i = 0; i < 6; i++) begin
            bp = tv[i].bp;
            if (!bp) dout_ready = 1'b1;
            t0 = cyc;
            id++;
            queue_hdr(tv[i].s, tv[i].e, tv[i].n, id);
            wait_done(done_n + 1, 2 * (tv[i].n + 5) + 60);
            chk("evt_count", evt_count, i + 1);
            chk("words_left", expq.size(), 0);
            chk("done_after_last", done_cyc, last_cyc + 1);
            if (!tv[i].bp) begin
                chk("rdreq_latency", rdreq_cyc, t0 + 1);
                chk("word0_latency", w0_cyc, t0 + 2);
                chk("first_sample_latency", s0_cyc, h4_cyc + 1);
            end
            bp = 0;
            dout_ready = 1'b1;
            repeat (2) tick();
        end

        // two headers queued back to back
        queue_hdr(12'h020, 12'h022, 3, ++id);
        queue_hdr(12'h030, 12'h031, 2, ++id);
        wait_done(done_n + 2, 100);
        chk("b2b_gap", gap, 4);
        chk("b2b_evt_count", evt_count, 8);
        chk("b2b_words_left", expq.size(), 0);
        repeat (2) tick();

        // enable low holds off the pop; dropping it mid-event does not stop the event
        enable = 1'b0;
        n0 = rdreq_n;
        queue_hdr(12'h200, 12'h20B, 12, ++id);
        repeat (10) tick();
        chk("disabled_no_rdreq", rdreq_n - n0, 0);
        chk("disabled_busy", busy, 0);
        chk("disabled_hdr_pending", hdr_empty, 0);
        enable = 1'b1;
        wait_wi(7, 50);
        enable = 1'b0;
        wait_done(done_n + 1, 100);
        chk("enable_evt_count", evt_count, 9);
        chk("enable_words_left", expq.size(), 0);
        enable = 1'b1;
        repeat (2) tick();

        // reset in the middle of the sample stream
        a_id = ++id;
        queue_hdr(12'h300, 12'h31F, 32, a_id);
        queue_hdr(12'h400, 12'h402, 3, ++id);
        wait_wi(10, 60);
        rst = 1'b0;
        tick();
        check_zero("samp_rst");
        while (expq.size() != 0 && expq[0].id == a_id) void'(expq.pop_front());
        if (stopq.size() != 0 && stopq[0].id == a_id) void'(stopq.pop_front());
        rst = 1'b1;
        n0 = done_n;
        wait_done(n0 + 1, 100);
        chk("post_rst_evt_count", evt_count, 1);
        chk("post_rst_words_left", expq.size(), 0);
        repeat (3) tick();
        chk("post_rst_done_pulses", done_n - n0, 1);
        chk("hdr_fifo_drained", hd == tl, 1);

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end

endmodule
